// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response codes, FSM state types and the register address decode
// used by the register slave.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Word index is the byte address with the two low bits dropped; word 0 is read-only.
  function automatic logic [1:0] decode_resp(input int unsigned addr,
                                             input int unsigned nreg,
                                             input logic        is_write);
    int unsigned index;
    index = addr >> 2;
    if (index >= nreg) return DECERR;
    if (is_write && index == 0) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite bus bundle (five channels, no strobes) with master and slave views.
interface axi_lite_reg_slave_if #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32
);
  logic             awvalid;
  logic [ASIZE-1:0] awaddr;
  logic             awready;
  logic             wvalid;
  logic [DSIZE-1:0] wdata;
  logic             wready;
  logic             bvalid;
  logic [1:0]       bresp;
  logic             bready;
  logic             arvalid;
  logic [ASIZE-1:0] araddr;
  logic             arready;
  logic             rvalid;
  logic [DSIZE-1:0] rdata;
  logic [1:0]       rresp;
  logic             rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register file: word 0 is a read-only ID, words 1..NREG-1 are read/write.
// Independent write (AW/W in any order) and read FSMs.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int               ASIZE    = 8,
  parameter int               DSIZE    = 32,
  parameter int               NREG     = 16,
  parameter logic [DSIZE-1:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                  axi_lite_aclk,
  input  logic                  axi_lite_resetn,
  axi_lite_reg_slave_if.slave   bus,
  output logic [NREG*DSIZE-1:0] reg_q
);

  localparam int IDXW = ASIZE - 2;

  logic [DSIZE-1:0] regs [1:NREG-1];

  w_state_e         w_state, w_state_d;
  logic             aw_done, aw_done_d, w_done, w_done_d;
  logic [ASIZE-1:0] aw_addr_q, aw_addr_d;
  logic [DSIZE-1:0] w_data_q, w_data_d;
  logic             awready_d, wready_d, bvalid_d;
  logic [1:0]       bresp_d, wr_resp;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;

  r_state_e         r_state, r_state_d;
  logic             arready_d, rvalid_d;
  logic [DSIZE-1:0] rdata_d, rd_word;
  logic [1:0]       rresp_d;
  logic [IDXW-1:0]  rd_idx;

  always_comb begin
    w_state_d = w_state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    bvalid_d  = bus.bvalid;
    bresp_d   = bus.bresp;
    wr_resp   = OKAY;
    wr_en     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (bus.awvalid && bus.awready) begin
          aw_done_d = 1'b1;
          aw_addr_d = bus.awaddr;
        end
        if (bus.wvalid && bus.wready) begin
          w_done_d = 1'b1;
          w_data_d = bus.wdata;
        end
        // Commit on the edge that completes whichever handshake came last.
        if (aw_done_d && w_done_d) begin
          wr_resp   = decode_resp(32'(aw_addr_d), NREG, 1'b1);
          wr_en     = (wr_resp == OKAY);
          bvalid_d  = 1'b1;
          bresp_d   = wr_resp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
    wr_idx    = aw_addr_d[ASIZE-1:2];
  end

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= OKAY;
    end else begin
      w_state     <= w_state_d;
      aw_done     <= aw_done_d;
      w_done      <= w_done_d;
      bus.awready <= awready_d;
      bus.wready  <= wready_d;
      bus.bvalid  <= bvalid_d;
      bus.bresp   <= bresp_d;
    end
  end

  // Captured address/data are only consumed while their flags are set.
  always_ff @(posedge axi_lite_aclk) begin
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
  end

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (wr_en && wr_idx == IDXW'(i)) regs[i] <= w_data_d;
    end
  end

  // Reads see the register array before any same-edge write lands.
  always_comb begin
    rd_idx  = bus.araddr[ASIZE-1:2];
    rd_word = ID_VALUE;
    for (int i = 1; i < NREG; i++)
      if (rd_idx == IDXW'(i)) rd_word = regs[i];
  end

  always_comb begin
    r_state_d = r_state;
    rvalid_d  = bus.rvalid;
    rdata_d   = bus.rdata;
    rresp_d   = bus.rresp;
    case (r_state)
      R_IDLE: begin
        if (bus.arvalid && bus.arready) begin
          rresp_d   = decode_resp(32'(bus.araddr), NREG, 1'b0);
          rdata_d   = (rresp_d == OKAY) ? rd_word : '0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= OKAY;
    end else begin
      r_state     <= r_state_d;
      bus.arready <= arready_d;
      bus.rvalid  <= rvalid_d;
      bus.rdata   <= rdata_d;
      bus.rresp   <= rresp_d;
    end
  end

  always_comb begin
    reg_q[DSIZE-1:0] = ID_VALUE;
    for (int i = 1; i < NREG; i++) reg_q[i*DSIZE +: DSIZE] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave: a word-array model of the register map
// is checked against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam int          ASIZE = 8;
  localparam int          DSIZE = 32;
  localparam int          NREG  = 16;
  localparam logic [31:0] IDV   = 32'hA11E_0001;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREG*DSIZE-1:0] reg_q;

  axi_lite_reg_slave_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  axi_lite_reg_slave #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREG(NREG), .ID_VALUE(IDV)) dut (
    .axi_lite_aclk  (clk),
    .axi_lite_resetn(resetn),
    .bus            (bus),
    .reg_q          (reg_q)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [NREG];
  logic [7:0]  pend_waddr, pend_raddr;
  logic [31:0] pend_wdata;
  logic [1:0]  last_bresp, last_rresp;
  logic [31:0] last_rdata;
  logic        pb_v, pb_hs, pr_v, pr_hs;
  logic [1:0]  pb_resp, pr_resp;
  logic [31:0] pr_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual no handshake within budget, required handshake", name);
  endtask

  function automatic logic [1:0] exp_wresp(input logic [7:0] a);
    int idx = int'(a) / 4;
    if (idx >= NREG) return 2'b11;
    if (idx == 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] a);
    return (int'(a) / 4 >= NREG) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [7:0] a);
    int idx = int'(a) / 4;
    return (idx >= NREG) ? 32'h0 : mdl[idx];
  endfunction

  // One model step per falling edge: responses, response stability and reg_q.
  task automatic compare_step();
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) mdl[i] = (i == 0) ? IDV : 32'h0;
      check("rst_ctrl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 0);
      check("rst_resp", {bus.bresp, bus.rresp}, 0);
      check("rst_rdata", bus.rdata, 0);
      pb_v = 0; pb_hs = 0; pr_v = 0; pr_hs = 0;
    end else begin
      if (bus.rvalid && (!pr_v || pr_hs)) begin
        check("r_data", bus.rdata, exp_rdata(pend_raddr));
        check("r_resp", bus.rresp, exp_rresp(pend_raddr));
      end else if (pr_v && !pr_hs) begin
        check("r_hold_valid", bus.rvalid, 1);
        check("r_hold_data", bus.rdata, pr_data);
        check("r_hold_resp", bus.rresp, pr_resp);
      end
      if (bus.bvalid && (!pb_v || pb_hs)) begin
        check("b_resp", bus.bresp, exp_wresp(pend_waddr));
        if (exp_wresp(pend_waddr) == 2'b00) mdl[int'(pend_waddr) / 4] = pend_wdata;
      end else if (pb_v && !pb_hs) begin
        check("b_hold_valid", bus.bvalid, 1);
        check("b_hold_resp", bus.bresp, pb_resp);
      end
      pr_v = bus.rvalid; pr_hs = bus.rvalid & bus.rready;
      pr_data = bus.rdata; pr_resp = bus.rresp;
      pb_v = bus.bvalid; pb_hs = bus.bvalid & bus.bready; pb_resp = bus.bresp;
    end
    for (int i = 0; i < NREG; i++) check($sformatf("reg_q_w%0d", i), reg_q[i*DSIZE +: DSIZE], mdl[i]);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_ok, w_ok;
    pend_waddr = addr;
    pend_wdata = data;
    fork
      begin
        @(posedge clk); repeat (aw_dly) @(posedge clk);
        #1 bus.awvalid = 1'b1; bus.awaddr = addr;
        aw_ok = 0;
        for (int c = 0; c < 64; c++) begin
          @(negedge clk);
          if (bus.awready) begin aw_ok = 1; break; end
        end
        @(posedge clk); #1 bus.awvalid = 1'b0;
        if (!aw_ok) timeout_fail("aw_handshake");
        else check("aw_drop", bus.awready, 0);
      end
      begin
        @(posedge clk); repeat (w_dly) @(posedge clk);
        #1 bus.wvalid = 1'b1; bus.wdata = data;
        w_ok = 0;
        for (int c = 0; c < 64; c++) begin
          @(negedge clk);
          if (bus.wready) begin w_ok = 1; break; end
        end
        @(posedge clk); #1 bus.wvalid = 1'b0;
        if (!w_ok) timeout_fail("w_handshake");
        else check("w_drop", bus.wready, 0);
      end
    join
    if (!(aw_ok && w_ok)) return;
    check("b_latency", bus.bvalid, 1);
    last_bresp = bus.bresp;
    repeat (b_dly) begin
      @(negedge clk);
      check("b_stall_valid", bus.bvalid, 1);
      check("b_stall_readies", {bus.awready, bus.wready}, 2'b00);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
    check("b_done", bus.bvalid, 0);
    check("b_readies_back", {bus.awready, bus.wready}, 2'b11);
  endtask

  task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
    bit ok;
    pend_raddr = addr;
    @(posedge clk); repeat (ar_dly) @(posedge clk);
    #1 bus.arvalid = 1'b1; bus.araddr = addr;
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1; break; end
    end
    @(posedge clk); #1 bus.arvalid = 1'b0;
    if (!ok) begin timeout_fail("ar_handshake"); return; end
    check("r_latency", bus.rvalid, 1);
    check("ar_drop", bus.arready, 0);
    last_rdata = bus.rdata;
    last_rresp = bus.rresp;
    repeat (r_dly) begin
      @(negedge clk);
      check("r_stall_valid", bus.rvalid, 1);
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    @(posedge clk); #1 bus.rready = 1'b0;
    check("r_done", bus.rvalid, 0);
    check("ar_back", bus.arready, 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("release_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0]  aw_a, ar_a;
    logic [31:0] d;
    int          kind;
    bit          ok;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    pb_v = 0; pb_hs = 0; pr_v = 0; pr_hs = 0; pb_resp = 0; pr_resp = 0; pr_data = 0;
    for (int i = 0; i < NREG; i++) mdl[i] = (i == 0) ? IDV : 32'h0;
    fork
      forever begin @(negedge clk); compare_step(); end
    join_none

    do_reset();

    do_write(8'h04, 32'hDEADBEEF, 0, 0, 0);
    check("same_cycle_bresp", last_bresp, 2'b00);
    do_read(8'h04, 0, 0);
    check("same_cycle_rdata", last_rdata, 32'hDEADBEEF);
    check("same_cycle_rresp", last_rresp, 2'b00);

    do_write(8'h08, 32'h12345678, 3, 0, 0);
    check("w_first_word2", reg_q[2*DSIZE +: DSIZE], 32'h12345678);

    do_write(8'h00, 32'hFFFFFFFF, 0, 1, 0);
    check("ro_bresp", last_bresp, 2'b10);
    do_read(8'h00, 0, 0);
    check("id_rdata", last_rdata, IDV);
    check("id_rresp", last_rresp, 2'b00);

    do_read(8'h40, 0, 2);
    check("dec_rresp", last_rresp, 2'b11);
    check("dec_rdata", last_rdata, 32'h0);
    do_write(8'h80, 32'hCAFEF00D, 1, 0, 0);
    check("dec_bresp", last_bresp, 2'b11);
    check("dec_word1", reg_q[1*DSIZE +: DSIZE], 32'hDEADBEEF);
    check("dec_word0", reg_q[0 +: DSIZE], IDV);

    do_write(8'h0C, 32'hA5A5A5A5, 0, 0, 5);
    check("stall_bresp", last_bresp, 2'b00);

    do_write(8'h14, 32'h11, 0, 0, 0);
    fork
      do_write(8'h14, 32'h22, 0, 0, 0);
      do_read(8'h14, 0, 0);
    join
    check("collide_rdata", last_rdata, 32'h11);
    check("collide_word5", reg_q[5*DSIZE +: DSIZE], 32'h22);

    do_write(8'h1B, 32'h77, 0, 0, 0);
    do_read(8'h18, 0, 0);
    check("lowbits_rdata", last_rdata, 32'h77);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 2));
      aw_a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, NREG-1) * 4 + $urandom_range(0, 3));
      ar_a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, NREG-1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ar_a = aw_a;
      d = $urandom;
      case (kind)
        0: do_write(aw_a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        1: do_read(ar_a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        default: fork
          do_write(aw_a, d, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
          do_read(ar_a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        join
      endcase
    end

    // Reset after only the address phase: the half-captured write must be forgotten.
    @(posedge clk); #1 bus.awvalid = 1'b1; bus.awaddr = 8'h10;
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.awready) begin ok = 1; break; end
    end
    @(posedge clk); #1 bus.awvalid = 1'b0;
    if (!ok) timeout_fail("partial_aw");
    #2 do_reset();
    check("partial_word4", reg_q[4*DSIZE +: DSIZE], 32'h0);
    do_write(8'h10, 32'h99, 0, 0, 0);
    check("after_partial_bresp", last_bresp, 2'b00);
    check("after_partial_word4", reg_q[4*DSIZE +: DSIZE], 32'h99);

    // Asynchronous reset while a read response is pending.
    do_write(8'h0C, 32'h55, 0, 0, 0);
    pend_raddr = 8'h0C;
    @(posedge clk); #1 bus.arvalid = 1'b1; bus.araddr = 8'h0C;
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1; break; end
    end
    @(posedge clk); #1 bus.arvalid = 1'b0;
    if (!ok) timeout_fail("async_ar");
    check("async_pre_rvalid", bus.rvalid, 1);
    check("async_pre_rdata", bus.rdata, 32'h55);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rvalid", bus.rvalid, 0);
    check("async_word0", reg_q[0 +: DSIZE], IDV);
    for (int i = 1; i < NREG; i++) check($sformatf("async_word%0d", i), reg_q[i*DSIZE +: DSIZE], 32'h0);
    do_reset();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
